// File: rtl/jtpopeye_dma.sv
// Vertical-blank sprite DMA: requests the Z80 bus on each blank start and
// copies LEN bytes from main work RAM at SRC_BASE into object RAM.
module jtpopeye_dma #(
  parameter logic [15:0] SRC_BASE = 16'h8C00,
  parameter int unsigned LEN      = 160,
  parameter int unsigned AW       = 10,
  parameter logic [7:0]  ACK_TO   = 8'd255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          dma_en,
  output logic          bus_req,
  input  logic          busak_n,
  output logic [15:0]   ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_din,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_dout,
  output logic          obj_we,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned CW = 10;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, RD, WR, REL} state_t;

  state_t          state, state_nx;
  logic            lvbl_l, pending, lvbl_fall;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [7:0]      ack_tmr, ack_tmr_nx, tmr_inc;
  logic            complete, complete_nx;
  logic            bus_req_nx, ram_rd_nx, obj_we_nx, busy_nx, done_nx, err_nx;
  logic [15:0]     ram_addr_nx;
  logic [AW-1:0]   obj_addr_nx;
  logic [7:0]      obj_dout_nx;

  assign lvbl_fall = lvbl_l & ~LVBL;
  assign tmr_inc   = ack_tmr + 8'd1;

  // Blank-start detect runs every clk; edges seen outside IDLE are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lvbl_l  <= 1'b0;
      pending <= 1'b0;
    end else begin
      lvbl_l <= LVBL;
      if (state != IDLE)
        pending <= 1'b0;
      else if (cen)
        pending <= pending ? 1'b0 : lvbl_fall;
      else if (lvbl_fall)
        pending <= 1'b1;
    end
  end

  // State and output registers, advanced on cen only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      ack_tmr  <= '0;
      complete <= 1'b0;
      bus_req  <= 1'b0;
      ram_rd   <= 1'b0;
      obj_we   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ram_addr <= SRC_BASE;
      obj_addr <= '0;
      obj_dout <= '0;
    end else if (cen) begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      ack_tmr  <= ack_tmr_nx;
      complete <= complete_nx;
      bus_req  <= bus_req_nx;
      ram_rd   <= ram_rd_nx;
      obj_we   <= obj_we_nx;
      busy     <= busy_nx;
      done     <= done_nx;
      err      <= err_nx;
      ram_addr <= ram_addr_nx;
      obj_addr <= obj_addr_nx;
      obj_dout <= obj_dout_nx;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    ack_tmr_nx  = ack_tmr;
    complete_nx = complete;
    bus_req_nx  = bus_req;
    ram_rd_nx   = ram_rd;
    obj_we_nx   = 1'b0;
    busy_nx     = busy;
    done_nx     = 1'b0;
    err_nx      = err;
    ram_addr_nx = ram_addr;
    obj_addr_nx = obj_addr;
    obj_dout_nx = obj_dout;

    case (state)
      IDLE: begin
        if (pending && dma_en) begin
          state_nx    = REQ;
          bus_req_nx  = 1'b1;
          busy_nx     = 1'b1;
          cnt_nx      = '0;
          ack_tmr_nx  = '0;
          complete_nx = 1'b0;
        end
      end
      REQ: begin
        if (!busak_n) begin
          state_nx = RD;
        end else begin
          ack_tmr_nx = tmr_inc;
          if (tmr_inc == ACK_TO) begin
            state_nx = REL;
            err_nx   = 1'b1;
          end
        end
      end
      RD: begin
        if (busak_n) begin
          state_nx  = REL;
          err_nx    = 1'b1;
          ram_rd_nx = 1'b0;
        end else begin
          ram_addr_nx = SRC_BASE + 16'(cnt);
          ram_rd_nx   = 1'b1;
          state_nx    = WR;
        end
      end
      WR: begin
        ram_rd_nx = 1'b0;
        if (busak_n) begin
          state_nx = REL;
          err_nx   = 1'b1;
        end else begin
          obj_dout_nx = ram_din;
          obj_addr_nx = AW'(cnt);
          obj_we_nx   = 1'b1;
          cnt_nx      = cnt + CW'(1);
          if (cnt == LAST) begin
            state_nx    = REL;
            complete_nx = 1'b1;
          end else begin
            state_nx = RD;
          end
        end
      end
      REL: begin
        bus_req_nx = 1'b0;
        busy_nx    = 1'b0;
        ram_rd_nx  = 1'b0;
        done_nx    = complete;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/jtpopeye_dma.md
Name: jtpopeye_dma

Overview:
- Vertical-blank sprite DMA controller for the Popeye main board.
- On each start of vertical blank it requests the Z80 bus through BUSRQ and waits for BUSAK.
- While it owns the bus it copies a fixed-length block from main-CPU work RAM into object RAM, then releases the bus.
- Sits between the main CPU wrapper (bus_req/busak_n, shared RAM port) and the object/sprite RAM used by video.

Parameters:
- SRC_BASE, 16'h8C00, main-RAM start address of the sprite table.
- LEN, 160, number of bytes per transfer (1..1023).
- AW, 10, object RAM address width.
- ACK_TO, 8'd255, cen ticks to wait for busak_n before giving up.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  CPU clock enable; all state changes occur only on cen=1 cycles
- LVBL  in  1  vertical blank, active low
- dma_en  in  1  transfer enable; sampled at the blank edge
- bus_req  out  1  bus request to CPU (drives BUSRQ_n = ~bus_req)
- busak_n  in  1  bus acknowledge from CPU, active low
- ram_addr  out  16  main-RAM address while owning the bus
- ram_rd  out  1  main-RAM read strobe
- ram_din  in  8  main-RAM data, valid on the cen tick after ram_rd
- obj_addr  out  AW  object RAM write address
- obj_dout  out  8  object RAM write data
- obj_we  out  1  object RAM write strobe, one cen tick wide
- busy  out  1  high from request until bus release
- done  out  1  one-cen-tick pulse when a complete transfer ends
- err  out  1  sticky; set on ack timeout or lost ack; cleared by reset only

Behaviour:
- Reset values: bus_req=0, ram_rd=0, obj_we=0, busy=0, done=0, err=0, ram_addr=SRC_BASE, obj_addr=0, obj_dout=0, state=IDLE, counters=0.
- Reset asserted mid-transfer drops bus_req immediately (asynchronously), without waiting for cen.
- Start detect:
  - LVBL is registered every clk.
  - A falling edge sets a pending flag.
  - The flag is consumed on the next cen tick in IDLE.
  - If dma_en=0 at consumption, the flag is cleared and no transfer occurs.
- States (advance only on cen):
  - IDLE: on pending & dma_en -> REQ; set bus_req=1, busy=1, clear byte counter and ack timer.
  - REQ: if busak_n=0 -> RD. Otherwise increment the ack timer; when it reaches ACK_TO -> REL with err=1.
  - RD: ram_addr = SRC_BASE + cnt, ram_rd=1 -> WR.
  - WR:
    - ram_rd=0; obj_dout <= ram_din; obj_addr <= cnt[AW-1:0]; obj_we=1; cnt <= cnt+1.
    - If cnt = LEN-1 -> REL and flag completion; else -> RD.
  - REL: bus_req=0, obj_we=0, busy=0; done=1 for this tick only if completion was flagged -> IDLE.
- Throughput: 2 cen ticks per byte.
  - First obj_we occurs 2 ticks after busak_n is seen low.
  - bus_req falls on the tick after the last write: LEN*2+1 ticks after ack.
- Lost ack: if busak_n returns high in RD or WR, go to REL, set err, and suppress done. Bytes already written remain.
- LVBL falling edge while busy: ignored and not queued; the pending flag is cleared when it is consumed.
- ram_addr arithmetic is 16-bit modulo and wraps at 16'hFFFF.
- obj_addr is truncated to AW bits.
- LEN=1 is legal: one RD/WR pair, then REL.
- cen=0 freezes all outputs and state except the asynchronous reset.

Test Plan:
1. Normal transfer: LEN=160; preload RAM[8C00+i]=i^8'h5A; busak_n falls 3 cen after bus_req -> 160 writes with obj[i]=i^5A; bus_req high for 3+321 ticks; one done pulse; err=0.
2. dma_en=0 at LVBL fall -> bus_req never asserts; no obj_we; busy stays 0.
3. Ack timeout: busak_n held high -> bus_req drops after 255 cen ticks; err=1; no done; no obj_we.
4. Lost ack: busak_n released high after byte 10 is written -> REL next tick; err=1; obj[0..10] written, obj[11] untouched; no done.
5. Reset mid-transfer at byte 50 -> bus_req=0 in the same clk cycle; all outputs at reset values; the next LVBL fall restarts from byte 0.
6. Wrap: SRC_BASE=16'hFFFE, LEN=4 -> reads FFFE, FFFF, 0000, 0001; second LVBL fall during busy is ignored (single done).
